pipelined_logic_unit: RTL

PIPELINED_LOGIC_UNIT -- requirements
Module: pipelined_logic_unit

---
 rtl/pipelined_logic_unit.sv | 64 ++++++
 1 files changed

// File: rtl/pipelined_logic_unit.sv
// pipelined_logic_unit: one-stage valid/ready bitwise logic unit with zero/parity flags
// and a wrapping count of accepted operand sets.
module pipelined_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_count,
  input  logic             clr_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic xfer;
  logic [WIDTH-1:0] res_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nxt;
  always_comb
    state_nxt = xfer ? FULL : (state == FULL && out_ready) ? EMPTY : state;
  always_comb begin
    out_valid = state == FULL;
    in_ready  = !out_valid || out_ready;
  end
  assign xfer = in_valid && in_ready;
  always_comb begin
    res_nxt = a;
    case (op)
      3'd0: res_nxt = a & b;
      3'd1: res_nxt = a | b;
      3'd2: res_nxt = ~a;
      3'd3: res_nxt = ~(a & b);
      3'd4: res_nxt = ~(a | b);
      3'd5: res_nxt = a ^ b;
      3'd6: res_nxt = ~(a ^ b);
      default: res_nxt = a;
    endcase
  end
  // Flags are derived from the same next value so all three outputs move together.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b1;
      parity <= 1'b0;
    end else if (xfer) begin
      result <= res_nxt;
      zero   <= ~|res_nxt;
      parity <= ^res_nxt;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) op_count <= '0;
    else if (clr_count) op_count <= '0;
    else if (xfer) op_count <= op_count + CNT_W'(1);
endmodule
